// File: rtl/mm_ctrl_pkg.sv
// Shared definitions for the memory-to-memory CPU control unit:
// opcode values, ALU operation codes, datapath mux selects, the
// controller state encoding and the control word that drives stage_5.
package mm_ctrl_pkg;

    // Datapath widths
    localparam int OPCODE_W = 8;
    localparam int ALU_OP_W = 4;

    // Opcodes as returned by the datapath op register
    localparam logic [OPCODE_W-1:0] OP_NOP  = 8'h00;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 8'h01;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 8'h02;
    localparam logic [OPCODE_W-1:0] OP_AND  = 8'h03;
    localparam logic [OPCODE_W-1:0] OP_OR   = 8'h04;
    localparam logic [OPCODE_W-1:0] OP_MOV  = 8'h05;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 8'h06;
    localparam logic [OPCODE_W-1:0] OP_BNE  = 8'h07;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 8'h08;
    localparam logic [OPCODE_W-1:0] OP_HALT = 8'hFF;

    // ALU operation select
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_PASS = 4'd4;

    // Memory address mux
    localparam logic [1:0] MA_PC   = 2'd0;
    localparam logic [1:0] MA_OPA  = 2'd1;
    localparam logic [1:0] MA_OPB  = 2'd2;
    localparam logic [1:0] MA_DEST = 2'd3;

    // Memory write-data mux
    localparam logic [1:0] MWD_ALU  = 2'd0;
    localparam logic [1:0] MWD_AREG = 2'd1;

    // ALU operand muxes
    localparam logic [1:0] SRCA_PC  = 2'd0;
    localparam logic [1:0] SRCA_A   = 2'd1;
    localparam logic [1:0] SRCB_B   = 2'd0;
    localparam logic [1:0] SRCB_INC = 2'd1;

    // Controller states; codes 11..15 are unused and recover to IDLE
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LOADA  = 4'd3,
        ST_LOADB  = 4'd4,
        ST_EXEC   = 4'd5,
        ST_WRITE  = 4'd6,
        ST_BRANCH = 4'd7,
        ST_JUMP   = 4'd8,
        ST_END    = 4'd9,
        ST_HALT   = 4'd10
    } ctrlState_t;

    // Every strobe and select the controller presents to the datapath
    typedef struct packed {
        logic                inputPC;
        logic                regOrPC;
        logic                valA;
        logic                branch;
        logic [1:0]          memAddr;
        logic [1:0]          memWriteData;
        logic [1:0]          ALUsrca;
        logic [1:0]          ALUsrcb;
        logic [ALU_OP_W-1:0] ALUOp;
        logic                writeOp;
        logic                writeA;
        logic                writeB;
        logic                writeDest;
        logic                writePC;
        logic                writeMem;
        logic                halted;
    } ctrlWord_t;

    // True for every opcode the controller knows how to sequence
    function automatic logic isLegalOp(input logic [OPCODE_W-1:0] op);
        return (op <= OP_JMP) || (op == OP_HALT);
    endfunction

    // ALU operation for the arithmetic/logic opcodes; anything else passes through
    function automatic logic [ALU_OP_W-1:0] aluOpFor(input logic [OPCODE_W-1:0] op);
        logic [ALU_OP_W-1:0] sel;
        case (op)
            OP_ADD:  sel = ALU_ADD;
            OP_SUB:  sel = ALU_SUB;
            OP_AND:  sel = ALU_AND;
            OP_OR:   sel = ALU_OR;
            default: sel = ALU_PASS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mm_ctrl_decode.sv
// Control-word decoder: maps the current state and the latched opcode
// to the full set of datapath strobes. Purely combinational; every
// field not named for a state stays zero.
module mm_ctrl_decode
    import mm_ctrl_pkg::*;
(
    input  ctrlState_t            state,
    input  logic [OPCODE_W-1:0]   opQ,
    output ctrlWord_t             cw
);

    // Moore decode of state (and latched opcode) into the control word
    always_comb begin
        cw = '0;
        case (state)
            ST_FETCH: begin
                // read instruction at PC, PC <= PC + increment
                cw.memAddr = MA_PC;
                cw.writeOp = 1'b1;
                cw.ALUsrca = SRCA_PC;
                cw.ALUsrcb = SRCB_INC;
                cw.ALUOp   = ALU_ADD;
                cw.inputPC = 1'b1;
                cw.regOrPC = 1'b1;
                cw.writePC = 1'b1;
            end
            ST_LOADA: begin
                cw.memAddr = MA_OPA;
                cw.writeA  = 1'b1;
            end
            ST_LOADB: begin
                cw.memAddr = MA_OPB;
                cw.writeB  = 1'b1;
            end
            ST_EXEC: begin
                cw.ALUsrca   = SRCA_A;
                cw.ALUsrcb   = SRCB_B;
                cw.ALUOp     = aluOpFor(opQ);
                cw.writeDest = 1'b1;
            end
            ST_WRITE: begin
                // MOV stores the A register directly, ALU ops store the result
                cw.memAddr      = MA_DEST;
                cw.writeMem     = 1'b1;
                cw.memWriteData = (opQ == OP_MOV) ? MWD_AREG : MWD_ALU;
            end
            ST_BRANCH: begin
                // compare A and B; the datapath gates the PC write with its
                // own equality result, so writePC stays low here
                cw.ALUsrca = SRCA_A;
                cw.ALUsrcb = SRCB_B;
                cw.ALUOp   = ALU_SUB;
                cw.branch  = 1'b1;
                cw.valA    = (opQ == OP_BEQ) ? 1'b1 : 1'b0;
                cw.regOrPC = 1'b0;
            end
            ST_JUMP: begin
                cw.regOrPC = 1'b0;
                cw.writePC = 1'b1;
            end
            ST_HALT: begin
                cw.halted = 1'b1;
            end
            ST_IDLE, ST_DECODE, ST_END: begin
                cw = '0;
            end
            default: begin
                cw = '0;
            end
        endcase
    end

endmodule

// File: rtl/mm_control_fsm.sv
// Multicycle control unit for the stage_5 memory-to-memory datapath.
// Holds the state register and the latched opcode; the control word is
// decoded from those registers alone, so an asynchronous reset drops
// every write enable before the next clock edge.
module mm_control_fsm
    import mm_ctrl_pkg::*;
#(
    parameter int OP_W    = OPCODE_W,
    parameter int ALUOP_W = ALU_OP_W
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               run,
    input  logic [OP_W-1:0]    OPOut,
    output logic               inputPC,
    output logic               regOrPC,
    output logic               valA,
    output logic               branch,
    output logic [1:0]         memAddr,
    output logic [1:0]         memWriteData,
    output logic [1:0]         ALUsrca,
    output logic [1:0]         ALUsrcb,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               writeOp,
    output logic               writeA,
    output logic               writeB,
    output logic               writeDest,
    output logic               writePC,
    output logic               writeMem,
    output logic               halted,
    output logic               illegal,
    output logic [3:0]         state_dbg
);

    ctrlState_t      stateQ;
    logic [OP_W-1:0] opQ;
    ctrlWord_t       cw;

    // State sequencing and opcode capture; OPOut is only looked at in DECODE
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            stateQ <= ST_IDLE;
            opQ    <= '0;
        end else begin
            case (stateQ)
                ST_IDLE: begin
                    stateQ <= run ? ST_FETCH : ST_IDLE;
                end
                ST_FETCH: begin
                    stateQ <= ST_DECODE;
                end
                ST_DECODE: begin
                    opQ <= OPOut;
                    case (OPOut)
                        OP_NOP:  stateQ <= ST_END;
                        OP_HALT: stateQ <= ST_HALT;
                        OP_JMP:  stateQ <= ST_JUMP;
                        OP_ADD, OP_SUB, OP_AND, OP_OR,
                        OP_MOV, OP_BEQ, OP_BNE:
                                 stateQ <= ST_LOADA;
                        default: stateQ <= ST_END;
                    endcase
                end
                ST_LOADA: begin
                    // MOV needs only the A operand
                    stateQ <= (opQ == OP_MOV) ? ST_WRITE : ST_LOADB;
                end
                ST_LOADB: begin
                    stateQ <= ((opQ == OP_BEQ) || (opQ == OP_BNE)) ? ST_BRANCH : ST_EXEC;
                end
                ST_EXEC: begin
                    stateQ <= ST_WRITE;
                end
                ST_WRITE, ST_BRANCH, ST_JUMP: begin
                    stateQ <= ST_END;
                end
                ST_END: begin
                    stateQ <= run ? ST_FETCH : ST_IDLE;
                end
                ST_HALT: begin
                    // only reset leaves HALT
                    stateQ <= ST_HALT;
                end
                default: begin
                    stateQ <= ST_IDLE;
                end
            endcase
        end
    end

    mm_ctrl_decode uDecode (
        .state (stateQ),
        .opQ   (opQ),
        .cw    (cw)
    );

    assign inputPC      = cw.inputPC;
    assign regOrPC      = cw.regOrPC;
    assign valA         = cw.valA;
    assign branch       = cw.branch;
    assign memAddr      = cw.memAddr;
    assign memWriteData = cw.memWriteData;
    assign ALUsrca      = cw.ALUsrca;
    assign ALUsrcb      = cw.ALUsrcb;
    assign ALUOp        = cw.ALUOp;
    assign writeOp      = cw.writeOp;
    assign writeA       = cw.writeA;
    assign writeB       = cw.writeB;
    assign writeDest    = cw.writeDest;
    assign writePC      = cw.writePC;
    assign writeMem     = cw.writeMem;
    assign halted       = cw.halted;
    assign state_dbg    = stateQ;

    // The opcode is only valid during DECODE itself, so the illegal flag is
    // the one output that looks at OPOut; it is gated by the DECODE state.
    assign illegal = (stateQ == ST_DECODE) && !isLegalOp(OPOut);

endmodule

// File: doc/mm_control_fsm.md
Name: mm_control_fsm

Overview:
- Multicycle control unit that drives the stage_5 datapath of the memory-to-memory CPU.
- Consumes the opcode byte the datapath returns (OPOut).
- Sequences fetch / decode / operand load / execute / write-back / branch.
- Produces every datapath control strobe and mux select, one state per clock.

Parameters:
OP_W, 8, opcode width (matches OPOut)
ALUOP_W, 4, ALU operation select width

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces IDLE and all-zero outputs
run  input  1  level; start/continue execution; sampled in IDLE and at instruction end
OPOut  input  OP_W  opcode from datapath op register; valid in the cycle after FETCH
inputPC, regOrPC, valA, branch  output  1 each  datapath selects/strobes
memAddr, memWriteData, ALUsrca, ALUsrcb  output  2 each  mux selects
ALUOp  output  ALUOP_W  ALU operation
writeOp, writeA, writeB, writeDest, writePC, writeMem  output  1 each  register/memory write enables
halted  output  1  high in HALT
illegal  output  1  one-cycle pulse when DECODE sees an undefined opcode
state_dbg  output  4  current state encoding

Behaviour:
- Clocking and reset: one clock (CLK). reset is asynchronous and active-high; on assertion go to IDLE, op_q=0x00, all outputs 0.
- Output style: Moore. Outputs are combinational from state and op_q only. No input-to-output combinational path.
- Opcodes: 00 NOP, 01 ADD, 02 SUB, 03 AND, 04 OR, 05 MOV, 06 BEQ, 07 BNE, 08 JMP, FF HALT. All others are illegal.
- ALUOp codes: ADD=0, SUB=1, AND=2, OR=3, PASS=4.
- memAddr: 0=PC, 1=opA, 2=opB, 3=dest.
- memWriteData: 0=ALU result, 1=A register.
- ALUsrca: 0=PC, 1=A. ALUsrcb: 0=B, 1=const increment.
- States and outputs (any output not listed is 0):
  - IDLE: run=1 -> FETCH.
  - FETCH: memAddr=0, writeOp=1, ALUsrca=0, ALUsrcb=1, ALUOp=ADD, inputPC=1, regOrPC=1, writePC=1 -> DECODE.
  - DECODE: op_q<=OPOut, no writes.
    - NOP -> END.
    - HALT -> HALT.
    - JMP -> JUMP.
    - 01..07 -> LOADA.
    - illegal -> END, illegal=1 for this cycle.
  - LOADA: memAddr=1, writeA=1. MOV -> WRITE; otherwise -> LOADB.
  - LOADB: memAddr=2, writeB=1. BEQ/BNE -> BRANCH; otherwise -> EXEC.
  - EXEC: ALUsrca=1, ALUsrcb=0, ALUOp from op_q (01->ADD, 02->SUB, 03->AND, 04->OR), writeDest=1 -> WRITE.
  - WRITE: memAddr=3, writeMem=1, memWriteData=1 if MOV else 0 -> END.
  - BRANCH: ALUsrca=1, ALUsrcb=0, ALUOp=SUB, branch=1, valA=1 for BEQ / 0 for BNE, regOrPC=0 -> END. The PC write is qualified by the datapath (branch AND isTrue); the FSM never asserts writePC here.
  - JUMP: regOrPC=0, writePC=1 -> END.
  - END: zero-output cycle. run=1 -> FETCH, else IDLE.
  - HALT: halted=1, sticky until reset; run ignored.
- Latency (FETCH through END inclusive):
  - NOP: 3 cycles.
  - JMP: 4 cycles.
  - MOV: 5 cycles.
  - BEQ/BNE: 6 cycles.
  - ALU ops: 7 cycles.
- run deasserted mid-instruction: the instruction completes; the FSM returns to IDLE at END.
- reset mid-instruction: abort immediately. No partial write may be asserted after reset assertion.
- OPOut is ignored in every state except DECODE. op_q is held until the next DECODE.
- Unused state encodings recover to IDLE on the next clock.

Decomposition:
- Package mm_ctrl_pkg: opcode constants, ALUOp constants, mux-select constants, state enum (4-bit), control-word struct.
- Sub-module mm_ctrl_decode: purely combinational state+op_q -> control word.
- mm_control_fsm holds the state register and op_q and instantiates mm_ctrl_decode.

Test Plan:
- Reset then run=1, OPOut=01 -> states IDLE, FETCH, DECODE, LOADA, LOADB, EXEC (ALUOp=0, writeDest=1), WRITE (memAddr=3, memWriteData=0, writeMem=1), END, FETCH.
- OPOut=06 -> BRANCH asserts branch=1, valA=1, ALUOp=1, writePC=0. OPOut=07 -> valA=0. Six cycles FETCH->END.
- OPOut=05 -> LOADA then WRITE with memWriteData=1, never EXEC. OPOut=08 -> JUMP with writePC=1, regOrPC=0.
- OPOut=3C -> illegal pulses exactly one cycle in DECODE, no write enables asserted, returns to FETCH.
- OPOut=FF -> HALT, halted=1 held for 20 cycles with run toggling. reset -> IDLE, halted=0.
- Assert reset asynchronously during EXEC of ADD -> all outputs 0 before the next CLK edge, state_dbg=IDLE. Deassert run during LOADB -> instruction completes, then IDLE.
